// File: rtl/cache_refill_ctrl_if.sv
// ---------------------------------------------------------------------------
// cache_refill_ctrl_if
//
// Bundles every handshake and bus signal of the cache refill controller so
// the controller, the upstream lookup path, the memory port and the cache
// array can be wired through a single port.
//
// Signal groups:
//   miss_*      upstream miss request (valid/ready plus byte address)
//   mem_req_*   burst read request towards memory (start address, len-1)
//   mem_beat_*  read data beats from memory (never back-pressured)
//   crit_*      critical-word response towards the requester
//   fill_*      full-line write towards the cache array (data + word mask)
//   busy        controller is working on a miss
//
// Modports:
//   master  the refill controller itself
//   slave   the surrounding environment (lookup path, memory, cache array)
// ---------------------------------------------------------------------------
interface cache_refill_ctrl_if #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int BEATS = 4
);

  localparam int LW = $clog2(BEATS);

  logic                  miss_vld;
  logic                  miss_rdy;
  logic [AW-1:0]         miss_addr;

  logic                  mem_req_vld;
  logic                  mem_req_rdy;
  logic [AW-1:0]         mem_req_addr;
  logic [LW-1:0]         mem_req_len;

  logic                  mem_beat_vld;
  logic [DW-1:0]         mem_beat_data;
  logic                  mem_beat_err;

  logic                  crit_vld;
  logic [DW-1:0]         crit_data;
  logic                  crit_err;

  logic                  fill_vld;
  logic                  fill_rdy;
  logic [AW-1:0]         fill_addr;
  logic [BEATS*DW-1:0]   fill_data;
  logic [BEATS-1:0]      fill_mask;

  logic                  busy;

  modport master (
    input  miss_vld, miss_addr,
    input  mem_req_rdy,
    input  mem_beat_vld, mem_beat_data, mem_beat_err,
    input  fill_rdy,
    output miss_rdy,
    output mem_req_vld, mem_req_addr, mem_req_len,
    output crit_vld, crit_data, crit_err,
    output fill_vld, fill_addr, fill_data, fill_mask,
    output busy
  );

  modport slave (
    output miss_vld, miss_addr,
    output mem_req_rdy,
    output mem_beat_vld, mem_beat_data, mem_beat_err,
    output fill_rdy,
    input  miss_rdy,
    input  mem_req_vld, mem_req_addr, mem_req_len,
    input  crit_vld, crit_data, crit_err,
    input  fill_vld, fill_addr, fill_data, fill_mask,
    input  busy
  );

endinterface

// File: rtl/cache_refill_ctrl.sv
// ---------------------------------------------------------------------------
// cache_refill_ctrl
//
// Miss-handling stage behind the cache lookup path. Takes one read miss at a
// time, issues a single burst read for the whole line (critical-word-first
// wrapping when WRAP=1, line-aligned incrementing when WRAP=0), forwards the
// requested word upstream as soon as it arrives and finally writes the whole
// line, with a per-word valid mask, into the cache array.
//
// Ports:
//   clk   clock
//   rstn  asynchronous active-low reset
//   bus   cache_refill_ctrl_if.master carrying the miss, memory request,
//         memory beat, critical-word, line-fill and busy signals
//
// Parameters:
//   AW     address width in bits
//   DW     data word width in bits (DW/8 bytes per word)
//   BEATS  words per line, power of two, at least 2
//   WRAP   1 = critical-word-first wrapping burst, 0 = incrementing burst
// ---------------------------------------------------------------------------
module cache_refill_ctrl #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int BEATS = 4,
  parameter int WRAP  = 1
) (
  input logic                 clk,
  input logic                 rstn,
  cache_refill_ctrl_if.master bus
);

  localparam int LW     = $clog2(BEATS);
  localparam int BW     = $clog2(DW / 8);
  localparam int LOBITS = LW + BW;

  localparam logic [AW-1:0] LINE_MASK = {AW{1'b1}} << LOBITS;
  localparam logic [LW-1:0] LAST_CNT  = LW'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    BEAT,
    FILL
  } state_e;

  state_e                state_q,    state_d;
  logic [AW-1:0]         lineAddr_q, lineAddr_d;
  logic [LW-1:0]         off_q,      off_d;
  logic [LW-1:0]         cnt_q,      cnt_d;
  logic [BEATS*DW-1:0]   data_q,     data_d;
  logic [BEATS-1:0]      mask_q,     mask_d;
  logic                  critVld_q,  critVld_d;
  logic [DW-1:0]         critData_q, critData_d;
  logic                  critErr_q,  critErr_d;

  logic [LW-1:0]         startOff;
  logic [LW-1:0]         beatIdx;

  // Burst start word within the line; the word slot of each beat follows from
  // it, and the LW-bit addition wraps naturally at the line boundary.
  assign startOff = (WRAP != 0) ? off_q : '0;
  assign beatIdx  = startOff + cnt_q;

  // All state lives here and is cleared asynchronously, so an aborted burst
  // leaves no partial line, mask or critical word behind.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      lineAddr_q <= '0;
      off_q      <= '0;
      cnt_q      <= '0;
      data_q     <= '0;
      mask_q     <= '0;
      critVld_q  <= 1'b0;
      critData_q <= '0;
      critErr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lineAddr_q <= lineAddr_d;
      off_q      <= off_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      mask_q     <= mask_d;
      critVld_q  <= critVld_d;
      critData_q <= critData_d;
      critErr_q  <= critErr_d;
    end
  end

  // Next-state logic. The mask is wiped when a miss is taken so bits of the
  // previous line cannot leak into the new fill. Beats are only consumed in
  // BEAT; an errored beat still counts and its data is still stored, only its
  // mask bit stays low. The critical-word pulse is a single cycle because it
  // defaults back to zero every cycle.
  always_comb begin
    state_d    = state_q;
    lineAddr_d = lineAddr_q;
    off_d      = off_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    mask_d     = mask_q;
    critVld_d  = 1'b0;
    critData_d = critData_q;
    critErr_d  = critErr_q;

    case (state_q)
      IDLE: begin
        if (bus.miss_vld) begin
          lineAddr_d = bus.miss_addr & LINE_MASK;
          off_d      = bus.miss_addr[BW +: LW];
          mask_d     = '0;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (bus.mem_req_rdy) begin
          cnt_d   = '0;
          state_d = BEAT;
        end
      end
      BEAT: begin
        if (bus.mem_beat_vld) begin
          data_d[beatIdx*DW +: DW] = bus.mem_beat_data;
          mask_d[beatIdx]          = ~bus.mem_beat_err;
          cnt_d                    = cnt_q + 1'b1;
          if (beatIdx == off_q) begin
            critVld_d  = 1'b1;
            critData_d = bus.mem_beat_data;
            critErr_d  = bus.mem_beat_err;
          end
          if (cnt_q == LAST_CNT) begin
            state_d = FILL;
          end
        end
      end
      FILL: begin
        if (bus.fill_rdy) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs come straight from registered state, so the request address and
  // the fill line are stable for as long as their valid is waiting on ready.
  assign bus.miss_rdy     = (state_q == IDLE);
  assign bus.mem_req_vld  = (state_q == REQ);
  assign bus.mem_req_addr = (WRAP != 0) ? (lineAddr_q | (AW'(off_q) << BW)) : lineAddr_q;
  assign bus.mem_req_len  = LAST_CNT;
  assign bus.crit_vld     = critVld_q;
  assign bus.crit_data    = critData_q;
  assign bus.crit_err     = critErr_q;
  assign bus.fill_vld     = (state_q == FILL);
  assign bus.fill_addr    = lineAddr_q;
  assign bus.fill_data    = data_q;
  assign bus.fill_mask    = mask_q;
  assign bus.busy         = (state_q != IDLE);

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cache_refill_ctrl
//
// Two controllers, one with WRAP=1 and one with WRAP=0, are driven in
// lockstep from the same stimulus; only where words land and when the
// critical word appears differ between them. A reference model that works
// purely in terms of beat number, word index and line arithmetic predicts
// every observed value.
// ---------------------------------------------------------------------------
module tb_cache_refill_ctrl;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int BEATS = 4;
  localparam int LW    = $clog2(BEATS);
  localparam int LINEW = BEATS * DW;
  localparam int WBYTES = DW / 8;
  localparam int LBYTES = BEATS * DW / 8;

  logic clk = 1'b0;
  logic rstn;

  always #5 clk = ~clk;

  logic            missVld;
  logic [AW-1:0]   missAddr;
  logic            memReqRdy;
  logic            beatVld;
  logic [DW-1:0]   beatData;
  logic            beatErr;
  logic            fillRdy;

  cache_refill_ctrl_if #(.AW(AW), .DW(DW), .BEATS(BEATS)) busWrap ();
  cache_refill_ctrl_if #(.AW(AW), .DW(DW), .BEATS(BEATS)) busInc ();

  // Both controllers see identical inputs.
  assign busWrap.miss_vld      = missVld;
  assign busWrap.miss_addr     = missAddr;
  assign busWrap.mem_req_rdy   = memReqRdy;
  assign busWrap.mem_beat_vld  = beatVld;
  assign busWrap.mem_beat_data = beatData;
  assign busWrap.mem_beat_err  = beatErr;
  assign busWrap.fill_rdy      = fillRdy;
  assign busInc.miss_vld       = missVld;
  assign busInc.miss_addr      = missAddr;
  assign busInc.mem_req_rdy    = memReqRdy;
  assign busInc.mem_beat_vld   = beatVld;
  assign busInc.mem_beat_data  = beatData;
  assign busInc.mem_beat_err   = beatErr;
  assign busInc.fill_rdy       = fillRdy;

  cache_refill_ctrl #(.AW(AW), .DW(DW), .BEATS(BEATS), .WRAP(1)) dutWrap (
    .clk  (clk),
    .rstn (rstn),
    .bus  (busWrap)
  );

  cache_refill_ctrl #(.AW(AW), .DW(DW), .BEATS(BEATS), .WRAP(0)) dutInc (
    .clk  (clk),
    .rstn (rstn),
    .bus  (busInc)
  );

  // Reference model state for the miss in flight.
  int               curOff;
  logic [AW-1:0]    curLine;
  int               beatNum;
  logic [LINEW-1:0] expDataW, expDataI;
  logic [BEATS-1:0] expMaskW, expMaskI;
  logic [DW-1:0]    expCritDataW, expCritDataI;
  logic             expCritErrW, expCritErrI;
  logic [AW-1:0]    expReqW, expReqI;

  int passCount  = 0;
  int checkCount = 0;

  // Single comparison point: counts the check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
  endtask

  // Advance one clock; sampling happens 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Which word of the line beat k carries for a given burst type.
  function automatic int wordIdx(input int wrap, input int off, input int k);
    return (wrap != 0) ? (off + k) % BEATS : k;
  endfunction

  // Everything observable after reset: idle and cleared, ready for a miss.
  task automatic checkResetState();
    checkOutput("rst miss_rdy",     busWrap.miss_rdy,     1'b1);
    checkOutput("rst busy",         busWrap.busy,         1'b0);
    checkOutput("rst mem_req_vld",  busWrap.mem_req_vld,  1'b0);
    checkOutput("rst mem_req_addr", busWrap.mem_req_addr, '0);
    checkOutput("rst fill_vld",     busWrap.fill_vld,     1'b0);
    checkOutput("rst fill_addr",    busWrap.fill_addr,    '0);
    checkOutput("rst fill_data",    busWrap.fill_data,    '0);
    checkOutput("rst fill_mask",    busWrap.fill_mask,    '0);
    checkOutput("rst crit_vld",     busWrap.crit_vld,     1'b0);
    checkOutput("rst crit_data",    busWrap.crit_data,    '0);
    checkOutput("rst crit_err",     busWrap.crit_err,     1'b0);
    checkOutput("rst inc miss_rdy", busInc.miss_rdy,      1'b1);
    checkOutput("rst inc busy",     busInc.busy,          1'b0);
    checkOutput("rst inc fill_mask", busInc.fill_mask,    '0);
    checkOutput("rst inc fill_data", busInc.fill_data,    '0);
  endtask

  // Idle cycles between beats: no critical-word pulse may appear.
  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      checkOutput("crit_vld idle wrap", busWrap.crit_vld, 1'b0);
      checkOutput("crit_vld idle inc",  busInc.crit_vld,  1'b0);
    end
  endtask

  // Present a miss, let it be accepted, and set up the model for the line.
  task automatic acceptMiss(input logic [AW-1:0] addr);
    missVld  = 1'b1;
    missAddr = addr;
    checkOutput("miss_rdy before accept", busWrap.miss_rdy, 1'b1);
    tick();
    missVld  = 1'b0;
    curOff   = int'((addr / WBYTES) % BEATS);
    curLine  = addr - (addr % LBYTES);
    expReqW  = curLine + AW'(curOff * WBYTES);
    expReqI  = curLine;
    beatNum  = 0;
    expMaskW = '0;
    expMaskI = '0;
    checkOutput("mem_req_vld wrap",  busWrap.mem_req_vld,  1'b1);
    checkOutput("mem_req_vld inc",   busInc.mem_req_vld,   1'b1);
    checkOutput("mem_req_addr wrap", busWrap.mem_req_addr, expReqW);
    checkOutput("mem_req_addr inc",  busInc.mem_req_addr,  expReqI);
    checkOutput("mem_req_len",       busWrap.mem_req_len,  BEATS - 1);
    checkOutput("mask cleared wrap", busWrap.fill_mask,    '0);
    checkOutput("mask cleared inc",  busInc.fill_mask,     '0);
    checkOutput("miss_rdy busy",     busWrap.miss_rdy,     1'b0);
    checkOutput("busy",              busWrap.busy,         1'b1);
  endtask

  // Hold off the request for a while (with spurious errored beats thrown in),
  // then accept it.
  task automatic reqHandshake(input int reqDelay);
    for (int i = 0; i < reqDelay; i++) begin
      memReqRdy = 1'b0;
      beatVld   = 1'b1;
      beatErr   = 1'b1;
      beatData  = DW'($urandom);
      tick();
      checkOutput("mem_req_vld held",  busWrap.mem_req_vld,  1'b1);
      checkOutput("mem_req_addr held", busWrap.mem_req_addr, expReqW);
      checkOutput("crit_vld in req",   busWrap.crit_vld,     1'b0);
    end
    memReqRdy = 1'b1;
    beatVld   = 1'($urandom_range(0, 1));
    beatErr   = 1'b1;
    tick();
    memReqRdy = 1'b0;
    beatVld   = 1'b0;
    beatErr   = 1'b0;
    checkOutput("mem_req_vld drop wrap", busWrap.mem_req_vld, 1'b0);
    checkOutput("mem_req_vld drop inc",  busInc.mem_req_vld,  1'b0);
  endtask

  // Deliver one beat and compare the critical-word and fill behaviour with
  // the model's idea of where this beat belongs.
  task automatic driveBeat(input logic [DW-1:0] data, input logic err);
    int iW;
    int iI;
    iW = wordIdx(1, curOff, beatNum);
    iI = wordIdx(0, curOff, beatNum);
    beatVld  = 1'b1;
    beatData = data;
    beatErr  = err;
    tick();
    beatVld  = 1'b0;
    beatErr  = 1'b0;
    expDataW[iW*DW +: DW] = data;
    expDataI[iI*DW +: DW] = data;
    expMaskW[iW] = !err;
    expMaskI[iI] = !err;
    checkOutput("crit_vld wrap", busWrap.crit_vld, iW == curOff);
    checkOutput("crit_vld inc",  busInc.crit_vld,  iI == curOff);
    if (iW == curOff) begin
      expCritDataW = data;
      expCritErrW  = err;
      checkOutput("crit_data wrap", busWrap.crit_data, expCritDataW);
      checkOutput("crit_err wrap",  busWrap.crit_err,  expCritErrW);
    end
    if (iI == curOff) begin
      expCritDataI = data;
      expCritErrI  = err;
      checkOutput("crit_data inc", busInc.crit_data, expCritDataI);
      checkOutput("crit_err inc",  busInc.crit_err,  expCritErrI);
    end
    beatNum++;
    checkOutput("fill_vld wrap", busWrap.fill_vld, beatNum == BEATS);
    checkOutput("fill_vld inc",  busInc.fill_vld,  beatNum == BEATS);
  endtask

  // One full miss: accept, request, all beats, fill with optional
  // back-pressure, optionally presenting the next miss during the fill.
  task automatic applyStimulus(input logic [AW-1:0] addr, input logic [BEATS-1:0] errBits,
                               input bit fixedData, input int reqDelay, input int fillDelay,
                               input bit holdNext, input logic [AW-1:0] nextAddr);
    logic [DW-1:0] d;
    acceptMiss(addr);
    reqHandshake(reqDelay);
    for (int k = 0; k < BEATS; k++) begin
      idleCycles($urandom_range(0, 2));
      d = fixedData ? DW'(32'hA0 + wordIdx(1, curOff, k)) : DW'($urandom);
      driveBeat(d, errBits[k]);
    end
    checkOutput("fill_addr wrap", busWrap.fill_addr, curLine);
    checkOutput("fill_addr inc",  busInc.fill_addr,  curLine);
    checkOutput("fill_data wrap", busWrap.fill_data, expDataW);
    checkOutput("fill_data inc",  busInc.fill_data,  expDataI);
    checkOutput("fill_mask wrap", busWrap.fill_mask, expMaskW);
    checkOutput("fill_mask inc",  busInc.fill_mask,  expMaskI);
    checkOutput("crit_data hold wrap", busWrap.crit_data, expCritDataW);
    checkOutput("crit_data hold inc",  busInc.crit_data,  expCritDataI);
    if (holdNext) begin
      missVld  = 1'b1;
      missAddr = nextAddr;
    end
    fillRdy = 1'b0;
    for (int i = 0; i < fillDelay; i++) begin
      tick();
      checkOutput("fill_vld held",  busWrap.fill_vld,  1'b1);
      checkOutput("fill_data held", busWrap.fill_data, expDataW);
      checkOutput("fill_mask held", busInc.fill_mask,  expMaskI);
      checkOutput("miss_rdy fill",  busWrap.miss_rdy,  1'b0);
    end
    fillRdy = 1'b1;
    tick();
    fillRdy = 1'b0;
    checkOutput("fill_vld done wrap", busWrap.fill_vld, 1'b0);
    checkOutput("fill_vld done inc",  busInc.fill_vld,  1'b0);
    checkOutput("busy done",          busWrap.busy,     1'b0);
  endtask

  logic [AW-1:0]    addrNow, addrNext;
  logic [LINEW-1:0] lineA;

  initial begin
    missVld   = 1'b0;
    missAddr  = '0;
    memReqRdy = 1'b0;
    beatVld   = 1'b0;
    beatData  = '0;
    beatErr   = 1'b0;
    fillRdy   = 1'b0;
    rstn      = 1'b1;
    #3 rstn = 1'b0;
    #3;
    checkResetState();
    tick();
    rstn = 1'b1;
    tick();

    $display("[TB] wrapping miss with OFF=2");
    applyStimulus(32'h011001F8, 4'b0000, 1'b1, 0, 0, 1'b0, '0);
    lineA = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    checkOutput("plan fill_data",    busWrap.fill_data,    lineA);
    checkOutput("plan fill_addr",    busWrap.fill_addr,    32'h011001F0);
    checkOutput("plan mem_req_addr", busWrap.mem_req_addr, 32'h011001F8);
    checkOutput("plan crit_data",    busWrap.crit_data,    32'hA2);
    checkOutput("plan fill_mask",    busWrap.fill_mask,    4'b1111);

    $display("[TB] spurious beat in IDLE");
    beatVld = 1'b1;
    beatErr = 1'b1;
    tick();
    beatVld = 1'b0;
    beatErr = 1'b0;
    checkOutput("spurious busy",      busWrap.busy,      1'b0);
    checkOutput("spurious crit_vld",  busWrap.crit_vld,  1'b0);
    checkOutput("spurious fill_mask", busWrap.fill_mask, expMaskW);

    $display("[TB] incrementing miss with OFF=1");
    applyStimulus(32'h022001F4, 4'b0000, 1'b0, 1, 0, 1'b0, '0);
    checkOutput("plan inc mem_req_addr", busInc.mem_req_addr, 32'h022001F0);

    $display("[TB] error beats");
    applyStimulus(32'h03300000, 4'b0100, 1'b0, 0, 0, 1'b0, '0);
    checkOutput("plan err mask",  busWrap.fill_mask, 4'b1011);
    checkOutput("plan err crit",  busWrap.crit_err,  1'b0);
    applyStimulus(32'h03300040, 4'b0001, 1'b0, 0, 0, 1'b0, '0);
    checkOutput("plan err1 mask", busWrap.fill_mask, 4'b1110);
    checkOutput("plan err1 crit", busWrap.crit_err,  1'b1);
    applyStimulus(32'h0440008C, 4'b1111, 1'b0, 0, 0, 1'b0, '0);
    checkOutput("all err mask",   busInc.fill_mask,  4'b0000);

    $display("[TB] back-pressure and back-to-back misses");
    applyStimulus(32'h05500014, 4'b0000, 1'b0, 3, 5, 1'b1, 32'h0660002C);
    applyStimulus(32'h0660002C, 4'b0010, 1'b0, 2, 3, 1'b0, '0);

    $display("[TB] randomized misses");
    addrNext = AW'($urandom);
    for (int n = 0; n < 20; n++) begin
      addrNow  = addrNext;
      addrNext = AW'($urandom);
      applyStimulus(addrNow, BEATS'($urandom & $urandom), 1'b0, $urandom_range(0, 3),
                    $urandom_range(0, 5), (n != 19) && ($urandom_range(0, 1) == 1), addrNext);
    end

    $display("[TB] reset mid-burst");
    acceptMiss(32'h0DD001F8);
    reqHandshake(1);
    driveBeat(DW'($urandom), 1'b0);
    driveBeat(DW'($urandom), 1'b0);
    #2 rstn = 1'b0;
    #1;
    checkResetState();
    tick();
    rstn = 1'b1;
    for (int k = 0; k < 2; k++) begin
      beatVld  = 1'b1;
      beatData = DW'($urandom);
      tick();
      checkOutput("aborted crit_vld", busWrap.crit_vld, 1'b0);
    end
    beatVld = 1'b0;
    tick();
    checkOutput("aborted fill_vld wrap", busWrap.fill_vld,  1'b0);
    checkOutput("aborted fill_vld inc",  busInc.fill_vld,   1'b0);
    checkOutput("aborted busy",          busWrap.busy,      1'b0);
    checkOutput("aborted fill_mask",     busWrap.fill_mask, '0);
    applyStimulus(32'h0EE001F0, 4'b0000, 1'b0, 0, 0, 1'b0, '0);
    checkOutput("post reset mask",       busWrap.fill_mask, 4'b1111);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
